dec_share_sched: RTL and testbench

// - Round-robin scheduler sharing one WIDTH-bit decrement unit (A-1, borrow flag) among NUM_CH countdown channels.
// - Each channel loads a start value, is decremented once per grant, and signals done on reaching zero.
// - Sits between requester blocks (timers/retry counters) and the shared decrement datapath; one write per cycle.

---
 rtl/dec_share_sched_pkg.sv | 23 ++
 rtl/dec_share_sched_dec_unit.sv | 32 +++
 rtl/dec_share_sched.sv | 167 ++++++++++++++++
 tb/tb_dec_share_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_share_sched_pkg.sv
// -----------------------------------------------------------------------------
// dec_sched_pkg
// Shared definitions for the round-robin countdown scheduler.
//   DEF_NUM_CH : default number of countdown channels
//   DEF_WIDTH  : default count width in bits
//   PTR_W      : width of a channel index / round-robin pointer at the defaults
//   count_t    : count value type at the default width
//   ch_state_t : per-channel state (IDLE = count zero, ACTIVE = counting)
// -----------------------------------------------------------------------------
package dec_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WIDTH  = 4;
    localparam int PTR_W      = $clog2(DEF_NUM_CH);

    typedef logic [DEF_WIDTH-1:0] count_t;

    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_t;

endpackage

// File: rtl/dec_share_sched_dec_unit.sv
// -----------------------------------------------------------------------------
// dec_unit
// Shared WIDTH-bit ripple decrementer: o_result = i_operand - 1.
//   i_operand : value to decrement
//   o_result  : i_operand - 1 (wraps to all ones on zero)
//   o_borrow  : set when i_operand is zero (underflow)
// -----------------------------------------------------------------------------
module dec_unit
    import dec_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_result,
    output logic             o_borrow
);

    logic w_borrow;

    // Subtracting one is a borrow rippling up from bit 0: each bit flips
    // while the borrow is live, and the borrow survives only through zeros.
    always_comb begin
        w_borrow = 1'b1;
        o_result = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_result[i] = i_operand[i] ^ w_borrow;
            w_borrow    = ~i_operand[i] & w_borrow;
        end
        o_borrow = w_borrow;
    end

endmodule

// File: rtl/dec_share_sched.sv
// -----------------------------------------------------------------------------
// dec_share_sched
// Round-robin scheduler that shares one decrement unit among NUM_CH countdown
// channels. Loads have priority over decrements, and at most one count
// register is written per cycle.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   en       : global decrement enable (loads are accepted regardless)
//   req      : per-channel load request, level, held until ack
//   ld_data  : load values, channel i at [i*WIDTH +: WIDTH]
//   ack      : load accepted this cycle (combinational, one-hot or zero)
//   busy     : channel holds a nonzero count
//   done     : registered one-cycle pulse when a channel reaches zero
//   rd_sel   : readback channel select
//   rd_count : count of channel rd_sel (combinational)
// -----------------------------------------------------------------------------
module dec_share_sched
    import dec_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WIDTH  = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*WIDTH-1:0]    ld_data,
    output logic [NUM_CH-1:0]          ack,
    output logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          done,
    input  logic [$clog2(NUM_CH)-1:0]  rd_sel,
    output logic [WIDTH-1:0]           rd_count
);

    localparam int SEL_W = $clog2(NUM_CH);

    logic [WIDTH-1:0] r_count [NUM_CH];
    ch_state_t        r_state [NUM_CH];
    logic [SEL_W-1:0] r_rr_ptr;
    logic [NUM_CH-1:0] r_done;

    logic             w_ld_valid;
    logic [SEL_W-1:0] w_ld_idx;
    logic [WIDTH-1:0] w_ld_value;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [SEL_W-1:0] w_ptr_next;
    logic             w_do_dec;
    logic [WIDTH-1:0] w_dec_operand;
    logic [WIDTH-1:0] w_dec_result;
    logic             w_dec_borrow;
    int               w_scan_idx;

    // A channel is busy exactly while its state is ACTIVE (nonzero count).
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (r_state[i] == CH_ACTIVE);
        end
    end

    // Fixed-priority load arbiter: scanning downwards leaves the lowest
    // requesting index as the winner.
    always_comb begin
        w_ld_valid = 1'b0;
        w_ld_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_ld_valid = 1'b1;
                w_ld_idx   = SEL_W'(i);
            end
        end
    end

    assign w_ld_value = ld_data[w_ld_idx*WIDTH +: WIDTH];

    // Ack is suppressed during reset so requesters never see a load accepted
    // that the registers will not take.
    always_comb begin
        ack = '0;
        if (rst_n && w_ld_valid) begin
            ack[w_ld_idx] = 1'b1;
        end
    end

    // Round-robin grant: first busy channel at or after the pointer, wrapping.
    // Scanning from the far end down means the closest match is written last.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NUM_CH) begin
                w_scan_idx = w_scan_idx - NUM_CH;
            end
            if (busy[SEL_W'(w_scan_idx)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = SEL_W'(w_scan_idx);
            end
        end
    end

    assign w_do_dec      = en && !w_ld_valid && w_gnt_valid;
    assign w_dec_operand = r_count[w_gnt_idx];
    assign w_ptr_next    = (w_gnt_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;

    dec_unit #(
        .WIDTH (WIDTH)
    ) u_dec_unit (
        .i_operand (w_dec_operand),
        .o_result  (w_dec_result),
        .o_borrow  (w_dec_borrow)
    );

    // Single write port into the count array: a load wins, otherwise the
    // granted channel takes the decremented value. Reaching zero either way
    // returns the channel to IDLE and raises its done pulse for one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_count[i] <= '0;
                r_state[i] <= CH_IDLE;
            end
            r_rr_ptr <= '0;
            r_done   <= '0;
        end else begin
            r_done <= '0;
            if (w_ld_valid) begin
                r_count[w_ld_idx] <= w_ld_value;
                if (w_ld_value == '0) begin
                    r_state[w_ld_idx] <= CH_IDLE;
                    r_done[w_ld_idx]  <= 1'b1;
                end else begin
                    r_state[w_ld_idx] <= CH_ACTIVE;
                end
            end else if (w_do_dec) begin
                r_count[w_gnt_idx] <= w_dec_result;
                r_rr_ptr           <= w_ptr_next;
                if (w_dec_result == '0) begin
                    r_state[w_gnt_idx] <= CH_IDLE;
                    r_done[w_gnt_idx]  <= 1'b1;
                end
            end
        end
    end

    // Only busy (nonzero) channels are granted, so the shared unit must
    // never underflow.
    always_ff @(posedge clk) begin
        if (rst_n && w_do_dec) begin
            assert (!w_dec_borrow)
                else $error("dec_share_sched: decrement unit underflow on channel %0d", w_gnt_idx);
        end
    end

    assign done = r_done;

    // Out-of-range selects (possible when NUM_CH is not a power of two) read 0.
    always_comb begin
        rd_count = '0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_count = r_count[rd_sel];
        end
    end

endmodule

// File: tb/tb_dec_share_sched.sv
// -----------------------------------------------------------------------------
// tb_dec_share_sched
// Directed self-checking bench for dec_share_sched (NUM_CH=4, WIDTH=4).
// Inputs change just after the falling edge; outputs are sampled there too,
// half a period away from the rising edge that updates the design.
// -----------------------------------------------------------------------------
module tb_dec_share_sched;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 4;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*WIDTH-1:0] ld_data;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [1:0]              rd_sel;
    logic [WIDTH-1:0]        rd_count;

    int checks   = 0;
    int failures = 0;

    dec_share_sched #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .ld_data  (ld_data),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .rd_sel   (rd_sel),
        .rd_count (rd_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] time limit reached");
    end

    // One comparison: counts it, and on mismatch counts the failure and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                failures++;
                $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            end
    endtask

    // Drive the request-side inputs.
    task automatic applyStimulus(input logic [NUM_CH-1:0] r,
                                 input logic [NUM_CH*WIDTH-1:0] d,
                                 input logic e);
        req     = r;
        ld_data = d;
        en      = e;
    endtask

    // Select a channel for readback and compare its count.
    task automatic readCount(input int ch, input logic [WIDTH-1:0] expected);
        rd_sel = 2'(ch);
        #1;
        checkOutput($sformatf("rd_count[%0d]", ch), 32'(rd_count), 32'(expected));
    endtask

    // Borrow must never be raised on a real grant.
    task automatic checkNoBorrow(input string tag);
        checkOutput(tag, 32'(dut.w_do_dec && dut.w_dec_borrow), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        rd_sel = '0;
        applyStimulus(4'b1111, 16'h4321, 1'b1);

        // Reset held three cycles with all requests high: no ack, all clear.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("reset_ack", 32'(ack), 32'h0);
        end
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        readCount(0, 4'h0);
        readCount(1, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        readCount(2, 4'h0);
        readCount(3, 4'h0);

        // Round-robin: ch0, ch1, ch3 each loaded with 2; pointer starts at 0.
        @(negedge clk);
        applyStimulus(4'b0001, 16'h0002, 1'b0);
        #1 checkOutput("rr_ack0", 32'(ack), 32'h1);
        @(negedge clk);
        applyStimulus(4'b0010, 16'h0020, 1'b0);
        #1 checkOutput("rr_ack1", 32'(ack), 32'h2);
        @(negedge clk);
        applyStimulus(4'b1000, 16'h2000, 1'b0);
        #1 checkOutput("rr_ack3", 32'(ack), 32'h8);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        checkOutput("rr_busy_start", 32'(busy), 32'hB);
        @(negedge clk);
        readCount(0, 4'h1);
        readCount(1, 4'h2);
        checkOutput("rr_done_g1", 32'(done), 32'h0);
        @(negedge clk);
        readCount(1, 4'h1);
        readCount(3, 4'h2);
        @(negedge clk);
        readCount(3, 4'h1);
        readCount(0, 4'h1);
        @(negedge clk);
        checkOutput("rr_done_ch0", 32'(done), 32'h1);
        readCount(0, 4'h0);
        checkOutput("rr_busy_after0", 32'(busy), 32'hA);
        @(negedge clk);
        checkOutput("rr_done_ch1", 32'(done), 32'h2);
        @(negedge clk);
        checkOutput("rr_done_ch3", 32'(done), 32'h8);
        checkOutput("rr_busy_end", 32'(busy), 32'h0);
        @(negedge clk);
        checkOutput("rr_done_clear", 32'(done), 32'h0);

        // Single channel: ch2 loaded with 3, done four cycles after the ack.
        applyStimulus(4'b0100, 16'h0300, 1'b1);
        #1 checkOutput("single_ack", 32'(ack), 32'h4);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        checkOutput("single_busy", 32'(busy), 32'h4);
        checkOutput("single_done_c1", 32'(done), 32'h0);
        readCount(2, 4'h3);
        @(negedge clk);
        readCount(2, 4'h2);
        checkOutput("single_done_c2", 32'(done), 32'h0);
        @(negedge clk);
        readCount(2, 4'h1);
        checkOutput("single_done_c3", 32'(done), 32'h0);
        @(negedge clk);
        readCount(2, 4'h0);
        checkOutput("single_done_c4", 32'(done), 32'h4);
        checkOutput("single_busy_end", 32'(busy), 32'h0);
        @(negedge clk);
        checkOutput("single_done_c5", 32'(done), 32'h0);

        // Load priority: ch0 made busy, then ch1 and ch2 request together.
        // Pointer is 3 here, so the first decrement after the loads hits ch0.
        applyStimulus(4'b0001, 16'h0974, 1'b0);
        #1 checkOutput("prio_ack_ch0", 32'(ack), 32'h1);
        @(negedge clk);
        applyStimulus(4'b0110, 16'h0974, 1'b1);
        #1 checkOutput("prio_ack_both", 32'(ack), 32'h2);
        @(negedge clk);
        applyStimulus(4'b0100, 16'h0974, 1'b1);
        #1 checkOutput("prio_ack_ch2", 32'(ack), 32'h4);
        readCount(0, 4'h4);
        readCount(1, 4'h7);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        readCount(0, 4'h4);
        readCount(2, 4'h9);
        checkOutput("prio_busy", 32'(busy), 32'h7);
        @(negedge clk);
        readCount(0, 4'h3);
        en = 1'b0;
        @(negedge clk);
        readCount(0, 4'h3);
        readCount(1, 4'h7);

        // Reset mid-count clears every channel without any done pulse.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_done", 32'(done), 32'h0);
        readCount(0, 4'h0);
        readCount(2, 4'h0);
        @(negedge clk);
        checkOutput("midrst_done_next", 32'(done), 32'h0);

        // Load value 0: done next cycle, never busy.
        applyStimulus(4'b0010, 16'h0000, 1'b1);
        #1 checkOutput("zero_ack", 32'(ack), 32'h2);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        checkOutput("zero_done", 32'(done), 32'h2);
        checkOutput("zero_busy", 32'(busy), 32'h0);
        @(negedge clk);
        checkOutput("zero_done_clear", 32'(done), 32'h0);

        // Load 4'hF: fifteen grants down to zero, borrow never raised.
        applyStimulus(4'b1000, 16'hF000, 1'b1);
        #1 checkOutput("max_ack", 32'(ack), 32'h8);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        readCount(3, 4'hF);
        checkOutput("max_busy", 32'(busy), 32'h8);
        for (int i = 1; i <= 15; i++) begin
            checkNoBorrow("max_borrow");
            @(negedge clk);
            readCount(3, 4'(15 - i));
            checkOutput($sformatf("max_done_%0d", i), 32'(done), (i == 15) ? 32'h8 : 32'h0);
        end
        checkOutput("max_busy_end", 32'(busy), 32'h0);

        // Restart: ch1 loaded with 1, then reloaded with 5 before it counts.
        @(negedge clk);
        applyStimulus(4'b0010, 16'h0010, 1'b1);
        #1 checkOutput("restart_ack1", 32'(ack), 32'h2);
        @(negedge clk);
        applyStimulus(4'b0010, 16'h0050, 1'b1);
        #1 checkOutput("restart_ack2", 32'(ack), 32'h2);
        readCount(1, 4'h1);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        readCount(1, 4'h5);
        checkOutput("restart_done_a", 32'(done), 32'h0);
        checkOutput("restart_busy", 32'(busy), 32'h2);
        @(negedge clk);
        readCount(1, 4'h4);
        checkOutput("restart_done_b", 32'(done), 32'h0);
        @(negedge clk);
        readCount(1, 4'h3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        readCount(1, 4'h0);
        checkOutput("restart_rst_busy", 32'(busy), 32'h0);
        checkOutput("restart_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        checkOutput("restart_rst_done_next", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
